// File: rtl/alu_bist.sv
// alu_bist -- built-in self-test initiator for the combinational ALU.
//
// Walks every 4-bit operation code (0..15, outer loop) over NUM_VECTORS
// pseudo-random operand vectors (inner loop). Each vector takes one DRIVE
// cycle and one CAPTURE cycle. Every ALU response is folded into a 32-bit
// MISR, and the final value is compared against GOLDEN.
//
// Optional build macro ALU_BIST_CHECK_EN adds hard per-vector sanity
// checks that feed the sticky check_err flag. When the macro is not
// defined, check_err stays 0.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start               one-cycle run request (ignored while busy)
//   busy, done, pass    run status; pass is valid while done=1
//   signature           current MISR value
//   check_err           sticky hard-check failure
//   alu_operation/alu_dataA/alu_dataB/alu_shamt   stimulus to the ALU
//   alu_saida/alu_zero/alu_of                      ALU response
module alu_bist #(
   parameter int unsigned NUM_VECTORS = 256,
   parameter logic [31:0] SEED        = 32'hACE1_0001,
   parameter logic [31:0] GOLDEN      = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [31:0] signature,
   output logic        check_err,
   output logic [3:0]  alu_operation,
   output logic [31:0] alu_dataA,
   output logic [31:0] alu_dataB,
   output logic [4:0]  alu_shamt,
   input  logic [31:0] alu_saida,
   input  logic        alu_zero,
   input  logic        alu_of
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SEED    = 3'd1;
   localparam logic [2:0] S_DRIVE   = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [15:0] VEC_LAST = 16'(NUM_VECTORS - 1);

   logic [2:0]  state;
   logic [31:0] lfsr;
   logic [3:0]  op_cnt;
   logic [15:0] vec_cnt;

   logic        div_zero;
   logic        last_vec;
   logic        last_all;
   logic [31:0] resp_saida;
   logic        resp_zero;
   logic [31:0] sig_next;
   logic [31:0] lfsr_next;
   logic        hard_fail;
   logic        err_next;

   always_comb begin
      // The first divide/remainder vector forces dataB=0. For that vector,
      // only the overflow flag is a defined response.
      div_zero   = ((op_cnt == 4'd12) || (op_cnt == 4'd13)) && (vec_cnt == '0);
      last_vec   = (vec_cnt == VEC_LAST);
      last_all   = last_vec && (op_cnt == 4'hF);
      resp_saida = div_zero ? '0 : alu_saida;
      resp_zero  = div_zero ? 1'b0 : alu_zero;
      sig_next   = {signature[30:0],
                    signature[31] ^ signature[21] ^ signature[1] ^ signature[0]}
                   ^ resp_saida ^ {30'b0, resp_zero, alu_of};
      // Galois right-shift form of x^32+x^22+x^2+x+1
      lfsr_next  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
`ifdef ALU_BIST_CHECK_EN
      hard_fail  = (!div_zero && (alu_zero != (alu_saida == '0)))
                 || ((op_cnt >= 4'd14) && (alu_saida != '0))
                 || (div_zero && !alu_of);
`else
      hard_fail  = 1'b0;
`endif
      err_next   = check_err | hard_fail;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         signature     <= '0;
         check_err     <= 1'b0;
         alu_operation <= '0;
         alu_dataA     <= '0;
         alu_dataB     <= '0;
         alu_shamt     <= '0;
         lfsr          <= '0;
         op_cnt        <= '0;
         vec_cnt       <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state     <= S_SEED;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  check_err <= 1'b0;
               end
            end
            S_SEED: begin
               lfsr      <= SEED;
               signature <= '1;
               op_cnt    <= '0;
               vec_cnt   <= '0;
               state     <= S_DRIVE;
            end
            S_DRIVE: begin
               alu_operation <= op_cnt;
               alu_dataA     <= lfsr;
               alu_dataB     <= div_zero ? '0 : {lfsr[15:0], lfsr[31:16]};
               alu_shamt     <= lfsr[4:0];
               state         <= S_CAPTURE;
            end
            S_CAPTURE: begin
               signature <= sig_next;
               check_err <= err_next;
               lfsr      <= lfsr_next;
               if (last_vec) begin
                  vec_cnt <= '0;
                  op_cnt  <= op_cnt + 4'd1;
               end else begin
                  vec_cnt <= vec_cnt + 16'd1;
               end
               if (last_all) begin
                  // pass is taken from the final update, not from the stale register
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (sig_next == GOLDEN) && !err_next;
               end else begin
                  state <= S_DRIVE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_bist.sv
module tb_alu_bist;

   localparam int unsigned NV     = 4;
   localparam logic [31:0] SEED_V = 32'hACE1_0001;
   localparam logic [31:0] GOLD   = 32'h0000_0000;
`ifdef ALU_BIST_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
   } drv_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, pass, check_err;
   logic [31:0] signature;
   logic [3:0]  alu_operation;
   logic [31:0] alu_dataA, alu_dataB;
   logic [4:0]  alu_shamt;
   logic [31:0] alu_saida;
   logic        alu_zero, alu_of;

   bit fault_op4  = 1'b0;
   bit fault_op15 = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   drv_t        exp_q[$];
   logic [31:0] exp_sig;
   logic        exp_err;
   logic [31:0] clean_sig;

   alu_bist #(.NUM_VECTORS(NV), .SEED(SEED_V), .GOLDEN(GOLD)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .pass(pass), .signature(signature), .check_err(check_err),
      .alu_operation(alu_operation), .alu_dataA(alu_dataA),
      .alu_dataB(alu_dataB), .alu_shamt(alu_shamt),
      .alu_saida(alu_saida), .alu_zero(alu_zero), .alu_of(alu_of)
   );

   always #5 clk = ~clk;

   // Reference ALU with optional planted faults: {result, zero, of}
   function automatic logic [33:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh,
                                          input bit f4, input bit f15);
      logic [31:0] r;
      logic        o;
      r = '0;
      o = 1'b0;
      case (op)
         4'd0: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
         4'd1: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = ~(a | b);
         4'd6: r = a << sh;
         4'd7: r = a >> sh;
         4'd8: r = $signed(a) >>> sh;
         4'd9: r = {31'b0, $signed(a) < $signed(b)};
         4'd10: r = {31'b0, a < b};
         4'd11: r = a * b;
         4'd12: if (b == '0) begin r = '1; o = 1'b1; end else r = a / b;
         4'd13: if (b == '0) begin r = '1; o = 1'b1; end else r = a % b;
         default: r = '0;
      endcase
      if (f4 && op == 4'd4) r[0] = 1'b1;
      if (f15 && op == 4'd15) r = 32'h1;
      return {r, (r == '0), o};
   endfunction

   assign {alu_saida, alu_zero, alu_of} =
      alu_fn(alu_operation, alu_dataA, alu_dataB, alu_shamt, fault_op4, fault_op15);

   function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
      logic fb;
      fb = s[0];
      s = s >> 1;
      if (fb) begin
         s[31] = ~s[31];
         s[21] = ~s[21];
         s[1]  = ~s[1];
         s[0]  = ~s[0];
      end
      return s;
   endfunction

   // Fill the scoreboard with the drive sequence; compute the final signature/error
   task automatic build_expect();
      logic [31:0] l, s, r;
      logic        z, o, dz;
      logic [33:0] resp;
      drv_t        d;
      exp_q.delete();
      l = SEED_V;
      s = 32'hFFFF_FFFF;
      exp_err = 1'b0;
      for (int op = 0; op < 16; op++) begin
         for (int v = 0; v < int'(NV); v++) begin
            dz   = (op == 12 || op == 13) && v == 0;
            d.op = 4'(op);
            d.a  = l;
            d.b  = dz ? 32'h0 : {l[15:0], l[31:16]};
            d.sh = l[4:0];
            exp_q.push_back(d);
            resp = alu_fn(d.op, d.a, d.b, d.sh, fault_op4, fault_op15);
            r = resp[33:2];
            z = resp[1];
            o = resp[0];
            if (CHK) begin
               if (!dz && (z != (r == 0))) exp_err = 1'b1;
               if (op >= 14 && r != 0) exp_err = 1'b1;
               if (dz && !o) exp_err = 1'b1;
            end
            if (dz) begin r = '0; z = 1'b0; end
            s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ r ^ {30'b0, z, o};
            l = lfsr_adv(l);
         end
      end
      exp_sig = s;
   endtask

   task automatic run_and_check(input string tag, input int pulse_a, input int pulse_b,
                                input int reset_at);
      int   busy_cnt;
      bit   finished;
      drv_t e;
      build_expect();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      busy_cnt = 0;
      finished = 1'b0;
      for (int k = 0; k < int'(32 * NV) + 40 && !finished; k++) begin
         if (k > 0) @(negedge clk);
         start = (k == pulse_a || k == pulse_b);
         if (busy) busy_cnt++;
         if (k == 0) begin
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0) begin
               miscompares++;
               $display("FAIL %s start_ack: busy=%b done=%b required busy=1 done=0", tag, busy, done);
            end
         end
         if (k == 2) begin
            vectors++;
            if (alu_operation !== 4'd0 || alu_dataA !== 32'hACE1_0001 ||
                alu_dataB !== 32'h0001_ACE1 || alu_shamt !== 5'd1) begin
               miscompares++;
               $display("FAIL %s first_drive: op=%0d A=%h B=%h sh=%0d required 0 ace10001 0001ace1 1",
                        tag, alu_operation, alu_dataA, alu_dataB, alu_shamt);
            end
         end
         if (k >= 2 && k % 2 == 0 && k <= int'(32 * NV)) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL %s drive_k%0d: scoreboard empty", tag, k);
            end else begin
               e = exp_q.pop_front();
               if (alu_operation !== e.op || alu_dataA !== e.a ||
                   alu_dataB !== e.b || alu_shamt !== e.sh) begin
                  miscompares++;
                  $display("FAIL %s drive_k%0d: got op=%0d A=%h B=%h sh=%0d required op=%0d A=%h B=%h sh=%0d",
                           tag, k, alu_operation, alu_dataA, alu_dataB, alu_shamt,
                           e.op, e.a, e.b, e.sh);
               end
            end
         end
         if (k == reset_at) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || signature !== 32'h0 ||
                check_err !== 1'b0 || alu_operation !== 4'h0 || alu_dataA !== 32'h0 ||
                alu_dataB !== 32'h0 || alu_shamt !== 5'h0) begin
               miscompares++;
               $display("FAIL %s midrun_reset: busy=%b done=%b pass=%b sig=%h err=%b op=%h A=%h B=%h sh=%h required all zero",
                        tag, busy, done, pass, signature, check_err, alu_operation,
                        alu_dataA, alu_dataB, alu_shamt);
            end
            exp_q.delete();
            return;
         end
         if (k > 0 && !busy && done) finished = 1'b1;
      end
      start = 1'b0;
      vectors++;
      if (!finished) begin
         miscompares++;
         $display("FAIL %s done_timeout: done=%b busy=%b required done within budget", tag, done, busy);
      end
      vectors++;
      if (busy_cnt != int'(1 + 32 * NV)) begin
         miscompares++;
         $display("FAIL %s busy_len: got %0d required %0d", tag, busy_cnt, 1 + 32 * NV);
      end
      vectors++;
      if (signature !== exp_sig) begin
         miscompares++;
         $display("FAIL %s signature: got %h required %h", tag, signature, exp_sig);
      end
      vectors++;
      if (check_err !== exp_err || pass !== ((exp_sig == GOLD) && !exp_err)) begin
         miscompares++;
         $display("FAIL %s status: check_err=%b pass=%b required check_err=%b pass=%b",
                  tag, check_err, pass, exp_err, (exp_sig == GOLD) && !exp_err);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || signature !== 32'h0 ||
          check_err !== 1'b0 || alu_operation !== 4'h0 || alu_dataA !== 32'h0 ||
          alu_dataB !== 32'h0 || alu_shamt !== 5'h0) begin
         miscompares++;
         $display("FAIL reset_values: busy=%b done=%b pass=%b sig=%h err=%b op=%h A=%h B=%h sh=%h required all zero",
                  busy, done, pass, signature, check_err, alu_operation, alu_dataA, alu_dataB, alu_shamt);
      end
   endtask

   task automatic test_basic_run();
      run_and_check("basic", -1, -1, -1);
      clean_sig = exp_sig;
   endtask

   task automatic test_restart_in_done();
      run_and_check("restart_done", -1, -1, -1);
   endtask

   task automatic test_fault_op4();
      fault_op4 = 1'b1;
      run_and_check("fault_op4", -1, -1, -1);
      fault_op4 = 1'b0;
      vectors++;
      if (signature === clean_sig || pass !== 1'b0) begin
         miscompares++;
         $display("FAIL fault_op4_detect: sig=%h pass=%b required sig!=%h pass=0", signature, pass, clean_sig);
      end
   endtask

   task automatic test_midrun_reset();
      run_and_check("midrun_reset", -1, -1, 60);
      run_and_check("after_reset", -1, -1, -1);
   endtask

   task automatic test_start_while_busy();
      run_and_check("start_busy", 10, 70, -1);
   endtask

   task automatic test_check_op15();
      fault_op15 = 1'b1;
      run_and_check("op15_stub", -1, -1, -1);
      fault_op15 = 1'b0;
      vectors++;
      if (check_err !== CHK || pass !== 1'b0) begin
         miscompares++;
         $display("FAIL op15_check: check_err=%b pass=%b required check_err=%b pass=0", check_err, pass, CHK);
      end
   endtask

   initial begin
      test_reset();
      test_basic_run();
      test_restart_in_done();
      test_fault_op4();
      test_midrun_reset();
      test_start_while_busy();
      test_check_op15();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Built-in self-test initiator for the processor's combinational ALU.
- Drives the ALU operation/operand interface through every 4-bit operation code using pseudo-random operands.
- Compresses each response (result, zero, of) into a 32-bit MISR signature and compares it against a golden value.
- Sits beside the ALU and muxes onto its inputs during test mode; the system controller starts it through a start/done handshake.

Parameters:
- NUM_VECTORS, 256: operand vectors applied per operation code (1..65535).
- SEED, 32'hACE1_0001: LFSR seed; must be nonzero.
- GOLDEN, 32'h0000_0000: expected final signature.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a run
- busy  output  1  run in progress
- done  output  1  run finished; held until next start or reset
- pass  output  1  valid when done=1
- signature  output  32  current MISR value
- check_err  output  1  sticky hard-check failure
- alu_operation  output  4  to ALU operation
- alu_dataA  output  32  to ALU dataA
- alu_dataB  output  32  to ALU dataB
- alu_shamt  output  5  to ALU shamt
- alu_saida  input  32  ALU result
- alu_zero  input  1  ALU zero flag
- alu_of  input  1  ALU overflow flag

Behaviour:
- One clock (clk). reset is synchronous and active-high.
- All outputs are registered.
- Reset values: busy=0, done=0, pass=0, signature=0, check_err=0, alu_operation=0, alu_dataA=0, alu_dataB=0, alu_shamt=0. FSM goes to IDLE.
- FSM states: IDLE, SEED, DRIVE, CAPTURE, DONE.
- IDLE/DONE, start=1: go to SEED.
  - busy=1, done=0, pass=0, check_err=0.
- SEED (1 cycle):
  - lfsr<=SEED, signature<=32'hFFFF_FFFF.
  - op counter<=0, vector counter<=0.
  - Next state: DRIVE.
- DRIVE (1 cycle):
  - alu_operation<=op.
  - alu_dataA<=lfsr.
  - alu_dataB<={lfsr[15:0],lfsr[31:16]}.
  - alu_shamt<=lfsr[4:0].
  - Divide/remainder override: for op 12 or 13 with vector index 0, alu_dataB<=0.
  - Next state: CAPTURE.
- CAPTURE (1 cycle): ALU inputs are stable; sample alu_saida/alu_zero/alu_of.
  - Normal MISR update: signature <= {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ alu_saida ^ {30'b0, alu_zero, alu_of}.
  - Divide-by-zero vectors (op 12/13, index 0): alu_saida and alu_zero are replaced by 0 in the update; only alu_of is folded.
  - lfsr advances once per vector. It is a Galois LFSR with polynomial x^32+x^22+x^2+x+1 and is never reseeded between operation codes.
  - Counter increments: vector counter first; on wrap at NUM_VECTORS-1, op increments.
  - After op 15, last vector: go to DONE. Otherwise go to DRIVE.
- DONE:
  - busy=0, done=1.
  - pass = (signature==GOLDEN) && !check_err.
  - ALU outputs hold their last values.
- Iteration order: op 0..15 outer, vector 0..NUM_VECTORS-1 inner.
- Latency: busy is high for exactly 1+32*NUM_VECTORS cycles after the cycle start is sampled.
- start while busy: ignored; no restart, no effect on the sequence.
- start in DONE: begins a new run identically to a start from IDLE.
- reset mid-run: next cycle returns to IDLE with reset values. No partial done is produced.
- Counters sized to hold 16*NUM_VECTORS without overflow.

Optional Feature:
- Macro: ALU_BIST_CHECK_EN.
- Defined: during CAPTURE, check_err sets (sticky until next start/reset) on any of:
  - alu_zero != (alu_saida==0), checked for all ops except the divide-by-zero vectors;
  - op 14 or 15 with alu_saida != 0;
  - op 12/13 divide-by-zero vector with alu_of != 1.
- Not defined: check_err is tied to 0 and pass depends only on the signature compare. Signature behaviour is identical in both builds.

Test Plan:
- Reset, NUM_VECTORS=4, start pulse -> busy high exactly 129 cycles, then done=1, busy=0.
  - First DRIVE cycle: alu_operation=0, alu_dataA=32'hACE1_0001, alu_dataB=32'h0001_ACE1, alu_shamt=5'd1.
- Real ALU, NUM_VECTORS=4: record signature S. Restart with start in DONE -> identical S (determinism). Rebuild with GOLDEN=S -> pass=1.
- Stub ALU forcing alu_saida[0]=1 for op 4 only -> final signature != S, pass=0.
- reset asserted at cycle 60 of a run -> next cycle all outputs at reset values. Fresh start then reproduces S.
- start pulsed again at cycles 10 and 70 of a run -> busy duration and alu_operation sequence unchanged, signature=S.
- ALU_BIST_CHECK_EN defined, stub returning 32'h1 for op 15 -> check_err=1, pass=0 even with GOLDEN matching. Macro undefined -> check_err=0.
